// File: rtl/cordic_rr_sched.sv
// Two-requester round-robin front end feeding an 8-step rotation-mode CORDIC
// that returns cos/sin (Q4.16) of an angle clamped to 0..90 degrees.
module cordic_rr_sched #(
  parameter logic [19:0] K_INIT = 20'h09B71
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in0_valid,
  input  logic [19:0] in0_angle,
  output logic        in0_ready,
  input  logic        in1_valid,
  input  logic [19:0] in1_angle,
  output logic        in1_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] out_x,
  output logic [19:0] out_y,
  output logic        out_id,
  output logic        out_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ROT = 2'd1, DONE = 2'd2} state_t;

  // atan(2^-i) in degrees with 4 fractional bits
  localparam logic signed [19:0] ATAN [8] = '{
    20'sh002D0, 20'sh001A9, 20'sh000E0, 20'sh00072,
    20'sh00039, 20'sh0001C, 20'sh0000E, 20'sh00007
  };
  localparam logic signed [19:0] ANGLE_MAX = 20'sh005A0;

  state_t             state_reg, state_next;
  logic signed [19:0] x_reg, x_next;
  logic signed [19:0] y_reg, y_next;
  logic signed [19:0] z_reg, z_next;
  logic [2:0]         iter_reg, iter_next;
  logic               last_id_reg, last_id_next;
  logic               out_valid_reg, out_valid_next;
  logic               out_id_reg, out_id_next;
  logic               out_err_reg, out_err_next;
  logic [19:0]        out_x_reg, out_x_next;
  logic [19:0]        out_y_reg, out_y_next;

  logic signed [19:0] x_sh [8];
  logic signed [19:0] y_sh [8];
  logic signed [19:0] x_rot, y_rot, z_rot;
  logic signed [19:0] sel_angle, clamp_angle;
  logic               clamp_err;
  logic               grant0, grant1;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_shift
      assign x_sh[gi] = x_reg >>> gi;
      assign y_sh[gi] = y_reg >>> gi;
    end
  endgenerate

  // Contention goes to whoever was not served last; a lone requester always wins.
  assign grant0    = in0_valid & (~in1_valid | last_id_reg);
  assign grant1    = in1_valid & (~in0_valid | ~last_id_reg);
  assign sel_angle = grant1 ? in1_angle : in0_angle;

  always_comb begin
    clamp_angle = sel_angle;
    clamp_err   = 1'b0;
    if (sel_angle[19]) begin
      clamp_angle = '0;
      clamp_err   = 1'b1;
    end else if (sel_angle > ANGLE_MAX) begin
      clamp_angle = ANGLE_MAX;
      clamp_err   = 1'b1;
    end
  end

  always_comb begin
    if (!z_reg[19]) begin
      x_rot = x_reg - y_sh[iter_reg];
      y_rot = y_reg + x_sh[iter_reg];
      z_rot = z_reg - ATAN[iter_reg];
    end else begin
      x_rot = x_reg + y_sh[iter_reg];
      y_rot = y_reg - x_sh[iter_reg];
      z_rot = z_reg + ATAN[iter_reg];
    end
  end

  always_comb begin
    state_next     = state_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    z_next         = z_reg;
    iter_next      = iter_reg;
    last_id_next   = last_id_reg;
    out_valid_next = out_valid_reg;
    out_id_next    = out_id_reg;
    out_err_next   = out_err_reg;
    out_x_next     = out_x_reg;
    out_y_next     = out_y_reg;
    in0_ready      = 1'b0;
    in1_ready      = 1'b0;
    case (state_reg)
      IDLE: begin
        in0_ready = grant0 & ~rst;
        in1_ready = grant1 & ~rst;
        if (grant0 | grant1) begin
          x_next       = K_INIT;
          y_next       = '0;
          z_next       = clamp_angle;
          iter_next    = '0;
          last_id_next = grant1;
          out_id_next  = grant1;
          out_err_next = clamp_err;
          state_next   = ROT;
        end
      end
      ROT: begin
        x_next    = x_rot;
        y_next    = y_rot;
        z_next    = z_rot;
        iter_next = iter_reg + 3'd1;
        if (iter_reg == 3'd7) begin
          out_x_next     = x_rot;
          out_y_next     = y_rot;
          out_valid_next = 1'b1;
          state_next     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      z_reg         <= '0;
      iter_reg      <= '0;
      last_id_reg   <= 1'b1;
      out_valid_reg <= 1'b0;
      out_id_reg    <= 1'b0;
      out_err_reg   <= 1'b0;
      out_x_reg     <= '0;
      out_y_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      z_reg         <= z_next;
      iter_reg      <= iter_next;
      last_id_reg   <= last_id_next;
      out_valid_reg <= out_valid_next;
      out_id_reg    <= out_id_next;
      out_err_reg   <= out_err_next;
      out_x_reg     <= out_x_next;
      out_y_reg     <= out_y_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_x     = out_x_reg;
  assign out_y     = out_y_reg;
  assign out_id    = out_id_reg;
  assign out_err   = out_err_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_cordic_rr_sched.sv
// Scoreboard bench for cordic_rr_sched: accepted angles push an ideal cos/sin
// expectation, completed results pop and compare within a CORDIC tolerance.
module tb_cordic_rr_sched;

  localparam int TOL = 32'h520;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in0_valid = 1'b0, in1_valid = 1'b0;
  logic [19:0] in0_angle = '0, in1_angle = '0;
  logic        in0_ready, in1_ready;
  logic        out_valid, out_id, out_err, busy;
  logic        out_ready = 1'b1;
  logic [19:0] out_x, out_y;

  cordic_rr_sched dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_angle(in0_angle), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_angle(in1_angle), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_id(out_id), .out_err(out_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int id;
    int err;
  } exp_t;

  exp_t sb_q[$];
  int   grant_q[$];
  int   outid_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   waiting = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp, input int tol);
    int d;
    n_checks++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d",
               tag, got, got, exp, exp, tol);
    end
  endtask

  function automatic exp_t model(input logic [19:0] ang, input int id);
    exp_t        e;
    logic [19:0] a;
    real         rad;
    a     = ang;
    e.err = 0;
    if (a[19]) begin
      a     = '0;
      e.err = 1;
    end else if (a > 20'h005A0) begin
      a     = 20'h005A0;
      e.err = 1;
    end
    rad  = (real'(a) / 16.0) * 3.141592653589793 / 180.0;
    e.x  = int'($cos(rad) * 65536.0);
    e.y  = int'($sin(rad) * 65536.0);
    e.id = id;
    return e;
  endfunction

  // Monitor: sample away from the active edge, push on accept, pop on handoff.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_readies", int'(in0_ready | in1_ready), 0, 0);
      sb_q.delete();
      waiting = 1'b0;
    end else begin
      check("both_ready", int'(in0_ready & in1_ready), 0, 0);
      if (in0_valid && in0_ready) begin
        sb_q.push_back(model(in0_angle, 0));
        grant_q.push_back(0);
        waiting = 1'b1;
        acc_cyc = cyc + 1;
      end
      if (in1_valid && in1_ready) begin
        sb_q.push_back(model(in1_angle, 1));
        grant_q.push_back(1);
        waiting = 1'b1;
        acc_cyc = cyc + 1;
      end
      if (waiting && out_valid) begin
        check("latency", cyc - acc_cyc, 8, 0);
        waiting = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected", 0, 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_x", int'($signed(out_x)), e.x, TOL);
          check("out_y", int'($signed(out_y)), e.y, TOL);
          check("out_id", int'(out_id), e.id, 0);
          check("out_err", int'(out_err), e.err, 0);
          $display("result id=%0d err=%0d x=%05h y=%05h exp_x=%0d exp_y=%0d",
                   out_id, out_err, out_x, out_y, e.x, e.y);
          outid_q.push_back(int'(out_id));
        end
      end
    end
  end

  task automatic send(input int id, input logic [19:0] ang);
    bit ok;
    ok = 1'b0;
    if (id == 0) begin
      in0_angle = ang;
      in0_valid = 1'b1;
    end else begin
      in1_angle = ang;
      in1_valid = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    if (!ok) check("timeout_accept", 0, 1, 0);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (!busy && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("timeout_idle", 0, 1, 0);
  endtask

  initial begin
    logic [19:0] ang;
    int          sx, sy, sid, serr;
    bit          ok;

    // Both requesters pending through reset; the first contention follows it.
    in0_angle = 20'h00100;
    in1_angle = 20'h00400;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0, 0);
    check("rst_out_x", int'(out_x), 0, 0);
    check("rst_out_y", int'(out_y), 0, 0);
    check("rst_out_id", int'(out_id), 0, 0);
    check("rst_out_err", int'(out_err), 0, 0);
    check("rst_busy", int'(busy), 0, 0);
    rst = 1'b0;

    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (grant_q.size() >= 4) begin
        ok = 1'b1;
        break;
      end
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    if (!ok) check("timeout_contention", 0, 1, 0);
    wait_idle();
    check("grant_count", grant_q.size(), 4, 0);
    check("outid_count", outid_q.size(), 4, 0);
    for (int i = 0; i < 4; i++) begin
      check("grant_seq", (i < grant_q.size()) ? grant_q[i] : -1, i % 2, 0);
      check("outid_seq", (i < outid_q.size()) ? outid_q[i] : -1, i % 2, 0);
    end

    // Directed angles: 30, 0, 90, and the two clamp directions.
    send(0, 20'h001E0); wait_idle();
    send(0, 20'h00000); wait_idle();
    send(1, 20'h005A0); wait_idle();
    send(0, 20'hFFF00); wait_idle();
    send(1, 20'h00640); wait_idle();

    for (int n = 0; n < 6; n++) begin
      ang = 20'($urandom_range(0, 32'h800)) - 20'h00100;
      send(int'($urandom_range(0, 1)), ang);
      wait_idle();
    end

    // Back-pressure: the result must hold while the consumer stalls.
    out_ready = 1'b0;
    send(1, 20'h00300);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("timeout_out_valid", 0, 1, 0);
    sx   = int'(out_x);
    sy   = int'(out_y);
    sid  = int'(out_id);
    serr = int'(out_err);
    in0_angle = 20'h00100;
    in0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", int'(out_valid), 1, 0);
      check("bp_x", int'(out_x), sx, 0);
      check("bp_y", int'(out_y), sy, 0);
      check("bp_id", int'(out_id), sid, 0);
      check("bp_err", int'(out_err), serr, 0);
      check("bp_busy", int'(busy), 1, 0);
      check("bp_ready0", int'(in0_ready), 0, 0);
    end
    in0_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", int'(out_valid), 0, 0);
    check("bp_release_busy", int'(busy), 0, 0);

    // Reset four rotations into a clamped in1 request.
    send(1, 20'h00700);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid", int'(out_valid), 0, 0);
    check("mid_rst_x", int'(out_x), 0, 0);
    check("mid_rst_y", int'(out_y), 0, 0);
    check("mid_rst_id", int'(out_id), 0, 0);
    check("mid_rst_err", int'(out_err), 0, 0);
    check("mid_rst_busy", int'(busy), 0, 0);
    repeat (12) @(posedge clk);
    #1;
    check("mid_rst_no_result", int'(out_valid), 0, 0);
    send(1, 20'h00200);
    wait_idle();
    check("sb_drained", sb_q.size(), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
